// File: rtl/img_pattern_gen.sv
// rtl/img_pattern_gen.sv - selectable VGA test-pattern source: bars, checker, gradient, bouncing box
module img_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int RW         = 3,
  parameter int GW         = 3,
  parameter int BW         = 2,
  parameter int BAR_COUNT  = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int GRAD_SHIFT = 6,
  parameter int BOX_SIZE   = 32,
  parameter int BOX_STEP   = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CE,
  input  logic [9:0]    PIX,
  input  logic [9:0]    LINE,
  input  logic [1:0]    MODE_IN,
  output logic [RW-1:0] R,
  output logic [GW-1:0] G,
  output logic [BW-1:0] B,
  output logic [7:0]    FRAME_CNT,
  output logic          FRAME_END
);
  localparam int BW_PIX = H_ACTIVE / BAR_COUNT;
  localparam logic [9:0]  H_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  BAR_LAST = 10'(BW_PIX - 1);
  localparam logic [10:0] H_LIM    = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM    = 11'(V_ACTIVE);
  localparam logic [10:0] BOX_SZ   = 11'(BOX_SIZE);
  localparam logic [10:0] STEP     = 11'(BOX_STEP);

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  mode_e          mode_q;
  logic [RW-1:0]  r_q, r_d;
  logic [GW-1:0]  g_q, g_d;
  logic [BW-1:0]  b_q, b_d;
  logic [7:0]     frame_cnt_q;
  logic           frame_end_q;
  logic [9:0]     bar_pos_q, bar_pos_d, pos_cur;
  logic [7:0]     bar_idx_q, bar_idx_d, idx_cur;
  logic [2:0]     bar_i;
  logic [9:0]     bx_q, by_q;
  logic           x_neg_q, y_neg_q;
  logic           active, fe_hit, chk, in_box;

  // One axis of the bounce: returns {negative_direction, new_position}.
  // Turning around steps back immediately, so the box never leaves the active area.
  function automatic logic [10:0] axis_next(input logic [9:0] pos, input logic neg,
                                            input logic [10:0] lim);
    logic [10:0] p;
    p = {1'b0, pos};
    if (!neg) begin
      if (p + BOX_SZ + STEP > lim) axis_next = {1'b1, 10'(p - STEP)};
      else                         axis_next = {1'b0, 10'(p + STEP)};
    end else begin
      if (p < STEP) axis_next = {1'b0, 10'(p + STEP)};
      else          axis_next = {1'b1, 10'(p - STEP)};
    end
  endfunction

  assign active = ({1'b0, PIX} < H_LIM) && ({1'b0, LINE} < V_LIM);
  assign fe_hit = (PIX == H_LAST) && (LINE == V_LAST);
  assign chk    = PIX[CHECK_LOG2] ^ LINE[CHECK_LOG2];
  assign in_box = ({1'b0, PIX} >= {1'b0, bx_q}) && ({1'b0, PIX} < ({1'b0, bx_q} + BOX_SZ)) &&
                  ({1'b0, LINE} >= {1'b0, by_q}) && ({1'b0, LINE} < ({1'b0, by_q} + BOX_SZ));

  // Bar position/index counters: cleared at the line start, index steps every BW_PIX pixels.
  always_comb begin
    pos_cur   = (PIX == '0) ? '0 : bar_pos_q;
    idx_cur   = (PIX == '0) ? '0 : bar_idx_q;
    bar_i     = idx_cur[2:0];
    bar_pos_d = pos_cur + 10'd1;
    bar_idx_d = idx_cur;
    if (pos_cur == BAR_LAST) begin
      bar_pos_d = '0;
      bar_idx_d = idx_cur + 8'd1;
    end
  end

  // Pixel colour for the active mode; blanking forces black.
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (active) begin
      case (mode_q)
        MODE_BARS: begin
          r_d = {RW{bar_i[2]}};
          g_d = {GW{bar_i[1]}};
          b_d = {BW{bar_i[0]}};
        end
        MODE_CHECK: begin
          r_d = {RW{chk}};
          g_d = {GW{chk}};
          b_d = {BW{chk}};
        end
        MODE_GRAD: begin
          r_d = RW'(PIX >> GRAD_SHIFT);
          g_d = GW'(LINE >> GRAD_SHIFT);
          b_d = frame_cnt_q[7 -: BW];
        end
        MODE_BOX: begin
          r_d = {RW{in_box}};
          g_d = {GW{in_box}};
          b_d = '1;
        end
        default: ;
      endcase
    end
  end

  // State register: everything advances only on CE; frame-end latches mode, counts and moves the box.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q      <= MODE_BARS;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      frame_cnt_q <= '0;
      frame_end_q <= 1'b0;
      bar_pos_q   <= '0;
      bar_idx_q   <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      x_neg_q     <= 1'b0;
      y_neg_q     <= 1'b0;
    end else if (CE) begin
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      bar_pos_q   <= bar_pos_d;
      bar_idx_q   <= bar_idx_d;
      frame_end_q <= fe_hit;
      if (fe_hit) begin
        mode_q               <= mode_e'(MODE_IN);
        frame_cnt_q          <= frame_cnt_q + 8'd1;
        {x_neg_q, bx_q}      <= axis_next(bx_q, x_neg_q, H_LIM);
        {y_neg_q, by_q}      <= axis_next(by_q, y_neg_q, V_LIM);
      end
    end
  end

  assign R         = r_q;
  assign G         = g_q;
  assign B         = b_q;
  assign FRAME_CNT = frame_cnt_q;
  assign FRAME_END = frame_end_q;

endmodule

// File: tb/tb_img_pattern_gen.sv
// tb/tb_img_pattern_gen.sv - self-checking bench for img_pattern_gen against a behavioural model
module tb_img_pattern_gen;
  logic       CLK = 1'b0;
  logic       RST, CE;
  logic [9:0] PIX, LINE;
  logic [1:0] MODE_IN;
  logic [2:0] R, G;
  logic [1:0] B;
  logic [7:0] FRAME_CNT;
  logic       FRAME_END;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int   m_mode, m_fcnt, m_nbox, last_pix;
  bit   bar_ok, e_cv;
  logic [2:0] e_r, e_g;
  logic [1:0] e_b;
  logic       e_fe;

  img_pattern_gen dut (
    .CLK(CLK), .RST(RST), .CE(CE), .PIX(PIX), .LINE(LINE), .MODE_IN(MODE_IN),
    .R(R), .G(G), .B(B), .FRAME_CNT(FRAME_CNT), .FRAME_END(FRAME_END)
  );

  always #5 CLK = ~CLK;

  // Triangle-wave bounce position after n frames for limit lim (lim divisible by step).
  function automatic int tri_pos(input int n, input int lim, input int step);
    int half, t;
    half = lim / step;
    t = n % (2 * half);
    return (t <= half) ? t * step : (2 * half - t) * step;
  endfunction

  function automatic logic [16:0] got_v();
    return {R, G, B, FRAME_CNT, FRAME_END};
  endfunction
  function automatic logic [16:0] exp_v();
    return {e_r, e_g, e_b, 8'(m_fcnt), e_fe};
  endfunction
  function automatic logic [16:0] mask_v();
    return e_cv ? 17'h1FFFF : 17'h001FF;
  endfunction

  task automatic model_pixel(input int pix, input int line);
    bit contig;
    int i, bx, by;
    contig = (pix == 0) || (bar_ok && pix == last_pix + 1);
    bar_ok = contig;
    last_pix = pix;
    e_cv = 1;
    e_r = 0; e_g = 0; e_b = 0;
    if (pix < 640 && line < 480) begin
      case (m_mode)
        0: if (contig) begin
             i = (pix / 80) % 8;
             e_r = (i >= 4) ? 3'd7 : 3'd0;
             e_g = ((i / 2) % 2 == 1) ? 3'd7 : 3'd0;
             e_b = (i % 2 == 1) ? 2'd3 : 2'd0;
           end else e_cv = 0;
        1: if (((pix / 32) + (line / 32)) % 2 == 1) begin e_r = 7; e_g = 7; e_b = 3; end
        2: begin e_r = 3'((pix / 64) % 8); e_g = 3'((line / 64) % 8); e_b = 2'(m_fcnt / 64); end
        default: begin
          bx = tri_pos(m_nbox, 608, 2);
          by = tri_pos(m_nbox, 448, 2);
          e_b = 3;
          if (pix >= bx && pix < bx + 32 && line >= by && line < by + 32) begin
            e_r = 7; e_g = 7;
          end
        end
      endcase
    end
  endtask

  task automatic drive(input logic rst, input logic ce, input int pix, input int line);
    RST = rst; CE = ce; PIX = 10'(pix); LINE = 10'(line);
    @(posedge CLK);
    if (rst) begin
      m_mode = 0; m_fcnt = 0; m_nbox = 0; bar_ok = 0; last_pix = 0;
      e_r = 0; e_g = 0; e_b = 0; e_fe = 0; e_cv = 1;
    end else if (ce) begin
      model_pixel(pix, line);
      e_fe = (pix == 639 && line == 479);
      if (e_fe) begin
        m_mode = int'(MODE_IN);
        m_fcnt = (m_fcnt + 1) % 256;
        m_nbox++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    MODE_IN = 2'd3;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'($urandom), $urandom_range(0, 1023), $urandom_range(0, 1023));
      checks++;
      if (got_v() !== 17'd0)
        $display("FAIL reset k=%0d: got %h expected 00000", k, got_v());
      if (got_v() !== 17'd0) errors++;
    end
  endtask

  task automatic test_bars();
    logic [7:0] want;
    MODE_IN = 2'd0;
    for (int p = 0; p <= 640; p++) begin
      drive(1'b0, 1'b1, p, 0);
      checks++;
      if ((got_v() & mask_v()) !== (exp_v() & mask_v())) begin
        errors++;
        $display("FAIL bars p=%0d: got %h expected %h", p, got_v(), exp_v());
      end
      if (p inside {0, 79, 80, 560, 639, 640}) begin
        want = (p == 80) ? 8'h03 : (p == 560 || p == 639) ? 8'hFF : 8'h00;
        checks++;
        if ({R, G, B} !== want) begin
          errors++;
          $display("FAIL bar_edge p=%0d: got rgb %h expected %h", p, {R, G, B}, want);
        end
      end
    end
  endtask

  task automatic test_mode_latch();
    int pulses, l;
    pulses = 0;
    for (int li = 0; li < 2; li++) begin
      l = (li == 0) ? 100 : 479;
      for (int p = 0; p <= 640; p++) begin
        MODE_IN = (li == 1 && p >= 600) ? 2'd1 : 2'($urandom);
        for (int g = int'($urandom % 4 == 0); g >= 0; g--) begin
          drive(1'b0, logic'(g == 0), p, l);
          checks++;
          if ((got_v() & mask_v()) !== (exp_v() & mask_v())) begin
            errors++;
            $display("FAIL latch l=%0d p=%0d: got %h expected %h", l, p, got_v(), exp_v());
          end
        end
        if (FRAME_END) pulses++;
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL frame_end_pulses: got %0d expected 1", pulses);
    end
    drive(1'b0, 1'b1, 32, 0);
    checks++;
    if ({R, G, B, FRAME_CNT} !== {8'hFF, 8'd1}) begin
      errors++;
      $display("FAIL checker_white: got %h expected ff01", {R, G, B, FRAME_CNT});
    end
    drive(1'b0, 1'b1, 32, 32);
    checks++;
    if ({R, G, B} !== 8'h00) begin
      errors++;
      $display("FAIL checker_black: got %h expected 00", {R, G, B});
    end
  endtask

  task automatic test_ce_hold();
    MODE_IN = 2'd0;
    drive(1'b0, 1'b1, 639, 479);
    for (int p = 0; p <= 640; p++) begin
      for (int g = 1; g >= 0; g--) begin
        drive(1'b0, logic'(g == 1), (g == 1) ? p : int'($urandom_range(0, 1023)),
              (g == 1) ? 5 : int'($urandom_range(0, 1023)));
        checks++;
        if ((got_v() & mask_v()) !== (exp_v() & mask_v())) begin
          errors++;
          $display("FAIL ce_hold p=%0d ce=%0d: got %h expected %h", p, g, got_v(), exp_v());
        end
        if (p == 79 || p == 80) begin
          checks++;
          if (B !== ((p == 80) ? 2'd3 : 2'd0)) begin
            errors++;
            $display("FAIL ce_bar_edge p=%0d: got B=%0d", p, B);
          end
        end
      end
    end
  endtask

  task automatic test_frame_cnt();
    int start;
    bit saw_wrap;
    logic [7:0] prev;
    saw_wrap = 0;
    MODE_IN = 2'd2;
    drive(1'b0, 1'b1, 639, 479);
    start = m_fcnt;
    prev = FRAME_CNT;
    for (int f = 0; f < 256; f++) begin
      drive(1'b0, 1'b1, 0, 0);
      checks++;
      if (got_v() !== exp_v()) begin
        errors++;
        $display("FAIL grad_pix0 f=%0d: got %h expected %h", f, got_v(), exp_v());
      end
      drive(1'b0, 1'b1, 639, 479);
      checks++;
      if (got_v() !== exp_v()) begin
        errors++;
        $display("FAIL grad_fe f=%0d: got %h expected %h", f, got_v(), exp_v());
      end
      if (prev == 8'd255 && FRAME_CNT == 8'd0) saw_wrap = 1;
      prev = FRAME_CNT;
    end
    checks++;
    if ({saw_wrap, FRAME_CNT} !== {1'b1, 8'(start)}) begin
      errors++;
      $display("FAIL frame_wrap: got wrap=%0d cnt=%0d expected 1 %0d", saw_wrap, FRAME_CNT, start);
    end
  endtask

  task automatic probe(input int x, input int y, input logic [7:0] want, input string nm);
    drive(1'b0, 1'b1, x, y);
    checks++;
    if ({R, G, B} !== want) begin
      errors++;
      $display("FAIL %s (%0d,%0d): got %h expected %h", nm, x, y, {R, G, B}, want);
    end
  endtask

  task automatic test_box();
    drive(1'b1, 1'b0, 0, 0);
    MODE_IN = 2'd3;
    for (int f = 1; f <= 305; f++) begin
      drive(1'b0, 1'b1, 639, 479);
      checks++;
      if (got_v() !== exp_v()) begin
        errors++;
        $display("FAIL box_fe f=%0d: got %h expected %h", f, got_v(), exp_v());
      end
      drive(1'b0, 1'b1, $urandom_range(0, 700), $urandom_range(0, 520));
      checks++;
      if (got_v() !== exp_v()) begin
        errors++;
        $display("FAIL box_pix f=%0d: got %h expected %h", f, got_v(), exp_v());
      end
      if (f == 304) begin
        probe(608, 288, 8'hFF, "box_right_in");
        probe(607, 288, 8'h03, "box_right_out");
      end
    end
    probe(606, 286, 8'hFF, "box_back_in");
    probe(605, 286, 8'h03, "box_back_left");
    probe(637, 317, 8'hFF, "box_back_corner");
    probe(638, 286, 8'h03, "box_back_right");
    probe(606, 318, 8'h03, "box_back_below");
  endtask

  task automatic test_reset_mid();
    for (int f = 0; f < 10; f++) drive(1'b0, 1'b1, 639, 479);
    drive(1'b0, 1'b1, 299, 200);
    drive(1'b1, 1'b1, 300, 200);
    checks++;
    if (got_v() !== 17'd0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 00000", got_v());
    end
    probe(0, 0, 8'h00, "post_reset_bars");
    MODE_IN = 2'd3;
    drive(1'b0, 1'b1, 639, 479);
    checks++;
    if ({FRAME_CNT, FRAME_END} !== {8'd1, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_cnt: got %0d/%0d expected 1/1", FRAME_CNT, FRAME_END);
    end
    probe(1, 1, 8'h03, "box_origin_out");
    probe(2, 2, 8'hFF, "box_origin_in");
    probe(33, 33, 8'hFF, "box_origin_far");
    probe(34, 34, 8'h03, "box_origin_past");
  endtask

  task automatic test_random();
    int p, l;
    logic ce;
    p = 0; l = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom % 50 == 0) MODE_IN = 2'($urandom);
      ce = ($urandom % 10) < 7;
      if ($urandom % 300 == 0) begin
        drive(1'b1, ce, p, l);
      end else begin
        drive(1'b0, ce, p, l);
        if (ce) begin
          case ($urandom % 40)
            0: begin p = 639; l = 479; end
            1: begin p = $urandom_range(0, 1023); l = $urandom_range(0, 1023); end
            default: begin
              p = p + 1;
              if (p >= 800) begin p = 0; l = (l + 1) % 525; end
            end
          endcase
        end
      end
      checks++;
      if ((got_v() & mask_v()) !== (exp_v() & mask_v())) begin
        errors++;
        $display("FAIL random k=%0d: got %h expected %h", k, got_v(), exp_v());
      end
    end
  endtask

  initial begin
    RST = 1'b0; CE = 1'b0; PIX = '0; LINE = '0; MODE_IN = '0;
    m_mode = 0; m_fcnt = 0; m_nbox = 0; last_pix = 0; bar_ok = 0; e_cv = 1;
    e_r = 0; e_g = 0; e_b = 0; e_fe = 0;
    test_reset();
    test_bars();
    test_mode_latch();
    test_ce_hold();
    test_frame_cnt();
    test_box();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
